ni_inject_arbiter: RTL and testbench

- Shares the router local injection port between the priority NI FIFO and the normal NI FIFO. The priority FIFO carries 2-flit interrupt packets; the normal FIFO carries multi-flit data packets.
- Packet-atomic: once a packet starts, the other source cannot interleave flits until its tail has been forwarded.
- Priority traffic wins at packet boundaries. A starvation counter guarantees normal traffic a grant after STARVE_LIMIT consecutive priority packets.
- Sits between the two NI FIFOs and the router local input buffer.

---
 rtl/ni_inject_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ni_inject_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ni_inject_arbiter.sv
// rtl/ni_inject_arbiter.sv - packet-atomic arbiter for the router local injection port
//
// Purpose:
//   Shares the router local injection port between the priority NI FIFO
//   (2-flit interrupt packets) and the normal NI FIFO (multi-flit data
//   packets). Packets are never interleaved. Priority wins at packet
//   boundaries, but normal traffic is forced through after STARVE_LIMIT
//   consecutive priority packets while it is waiting.
//   Optional feature macro: NI_INJECT_TIMEOUT_EN (stalled-packet forced close).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pri_fifo_data/empty/rd     priority FIFO head word (FWFT), empty flag, pop
//   norm_fifo_data/empty/rd    normal FIFO head word (FWFT), empty flag, pop
//   router_ready               local port accepts a flit this cycle
//   flit_out, flit_valid       registered flit to the router
//   grant_pri                  current/last packet came from the priority FIFO
//   err_drop                   one-cycle pulse on a discarded flit
module ni_inject_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3,
   parameter int TIMEOUT      = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pri_fifo_data,
   input  logic        pri_fifo_empty,
   output logic        pri_fifo_rd,
   input  logic [15:0] norm_fifo_data,
   input  logic        norm_fifo_empty,
   output logic        norm_fifo_rd,
   input  logic        router_ready,
   output logic [15:0] flit_out,
   output logic        flit_valid,
   output logic        grant_pri,
   output logic        err_drop
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] PRI_PKT  = 2'd1;
   localparam logic [1:0] NORM_PKT = 2'd2;

   localparam logic [2:0] TYPE_HEAD = 3'b001;
   localparam logic [2:0] TYPE_TAIL = 3'b110;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [1:0]       state;
   logic [CNT_W-1:0] starve_cnt;
   logic             load_en;
   logic             timeout_fire;

   // The output register can take a new word when empty or draining this cycle.
   assign load_en = !flit_valid || router_ready;

   // Pop strobes are combinational so a popped word lands in flit_out on the
   // very next edge. Held low during reset so nothing is consumed.
   always_comb begin
      pri_fifo_rd  = 1'b0;
      norm_fifo_rd = 1'b0;
      if (rst_n && load_en && !timeout_fire) begin
         case (state)
            IDLE: begin
               if (!pri_fifo_empty && (starve_cnt < LIMIT || norm_fifo_empty))
                  pri_fifo_rd = 1'b1;
               else if (!norm_fifo_empty)
                  norm_fifo_rd = 1'b1;
            end
            PRI_PKT:  pri_fifo_rd  = !pri_fifo_empty;
            NORM_PKT: norm_fifo_rd = !norm_fifo_empty;
            default: ;
         endcase
      end
   end

`ifdef NI_INJECT_TIMEOUT_EN
   localparam int ST_W = $clog2(TIMEOUT + 1);

   logic [ST_W-1:0] stall_cnt;
   logic            own_empty;

   // Stall means the packet owner has nothing to give us; router back-pressure
   // alone does not count.
   assign own_empty = (state == PRI_PKT  && pri_fifo_empty) ||
                      (state == NORM_PKT && norm_fifo_empty);
   assign timeout_fire = own_empty && load_en && (stall_cnt == ST_W'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (!own_empty || timeout_fire)
         stall_cnt <= '0;
      else if (stall_cnt != ST_W'(TIMEOUT))
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign timeout_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flit_out   <= '0;
         flit_valid <= 1'b0;
         grant_pri  <= 1'b0;
         err_drop   <= 1'b0;
         state      <= IDLE;
         starve_cnt <= '0;
      end else begin
         err_drop <= 1'b0;
         if (load_en) begin
            // Cleared unless a word is loaded below; flit_out itself holds.
            flit_valid <= 1'b0;
            if (timeout_fire) begin
               flit_out   <= {TYPE_TAIL, 13'd0};
               flit_valid <= 1'b1;
               err_drop   <= 1'b1;
               state      <= IDLE;
            end else begin
               case (state)
                  IDLE: begin
                     if (pri_fifo_rd) begin
                        if (pri_fifo_data[15:13] == TYPE_HEAD) begin
                           flit_out   <= pri_fifo_data;
                           flit_valid <= 1'b1;
                           grant_pri  <= 1'b1;
                           state      <= PRI_PKT;
                           if (norm_fifo_empty)
                              starve_cnt <= '0;
                           else if (starve_cnt != LIMIT)
                              starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                           err_drop <= 1'b1;
                        end
                     end else if (norm_fifo_rd) begin
                        if (norm_fifo_data[15:13] == TYPE_HEAD) begin
                           flit_out   <= norm_fifo_data;
                           flit_valid <= 1'b1;
                           grant_pri  <= 1'b0;
                           state      <= NORM_PKT;
                           starve_cnt <= '0;
                        end else begin
                           err_drop <= 1'b1;
                        end
                     end
                  end
                  PRI_PKT: begin
                     if (pri_fifo_rd) begin
                        flit_out   <= pri_fifo_data;
                        flit_valid <= 1'b1;
                        if (pri_fifo_data[15:13] == TYPE_TAIL)
                           state <= IDLE;
                     end
                  end
                  NORM_PKT: begin
                     if (norm_fifo_rd) begin
                        flit_out   <= norm_fifo_data;
                        flit_valid <= 1'b1;
                        if (norm_fifo_data[15:13] == TYPE_TAIL)
                           state <= IDLE;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// tb/tb_ni_inject_arbiter.sv - self-checking bench for ni_inject_arbiter
module tb_ni_inject_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] pri_fifo_data;
   logic        pri_fifo_empty;
   logic        pri_fifo_rd;
   logic [15:0] norm_fifo_data;
   logic        norm_fifo_empty;
   logic        norm_fifo_rd;
   logic        router_ready;
   logic [15:0] flit_out;
   logic        flit_valid;
   logic        grant_pri;
   logic        err_drop;

   ni_inject_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pri_fifo_data   (pri_fifo_data),
      .pri_fifo_empty  (pri_fifo_empty),
      .pri_fifo_rd     (pri_fifo_rd),
      .norm_fifo_data  (norm_fifo_data),
      .norm_fifo_empty (norm_fifo_empty),
      .norm_fifo_rd    (norm_fifo_rd),
      .router_ready    (router_ready),
      .flit_out        (flit_out),
      .flit_valid      (flit_valid),
      .grant_pri       (grant_pri),
      .err_drop        (err_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pe;
      logic [15:0] pd;
      logic        ne;
      logic [15:0] nd;
      logic        rdy;
      logic        x_prd;
      logic        x_nrd;
      logic [15:0] x_flit;
      logic        x_val;
      logic        x_gp;
      logic        x_err;
   } vec_t;

   vec_t tbl[17];

   int tests = 0;
   int fails = 0;

   logic [15:0] pri_q[$];
   logic [15:0] norm_q[$];
   logic [15:0] out_q[$];
   logic [15:0] exp_q[$];
   int          drops;
   int          violations;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      pri_fifo_empty  = 1'b1;
      pri_fifo_data   = 16'h0;
      norm_fifo_empty = 1'b1;
      norm_fifo_data  = 16'h0;
      router_ready    = 1'b1;
      pri_q.delete();
      norm_q.delete();
      out_q.delete();
      exp_q.delete();
      drops      = 0;
      violations = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One cycle against the queue-backed FIFO models; starts and ends at posedge+1.
   task automatic step(input logic rdy);
      logic got_p, got_n;
      pri_fifo_empty  = (pri_q.size() == 0);
      pri_fifo_data   = (pri_q.size() != 0) ? pri_q[0] : 16'h0;
      norm_fifo_empty = (norm_q.size() == 0);
      norm_fifo_data  = (norm_q.size() != 0) ? norm_q[0] : 16'h0;
      router_ready    = rdy;
      #2;
      got_p = pri_fifo_rd;
      got_n = norm_fifo_rd;
      if (flit_valid && router_ready) out_q.push_back(flit_out);
      if (err_drop) drops++;
      if (got_p && got_n) violations++;
      if (got_p && pri_q.size() == 0) violations++;
      if (got_n && norm_q.size() == 0) violations++;
      @(posedge clk);
      #1;
      if (got_p && pri_q.size() != 0) void'(pri_q.pop_front());
      if (got_n && norm_q.size() != 0) void'(norm_q.pop_front());
   endtask

   task automatic compare_out(input string name);
      chk({name, "_count"}, 16'(out_q.size()), 16'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         chk($sformatf("%s_flit%0d", name, i), out_q[i], exp_q[i]);
      chk({name, "_pop_violations"}, 16'(violations), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // pe, pd, ne, nd, rdy | pri_rd, norm_rd, flit_out, flit_valid, grant_pri, err_drop
      tbl[0]  = '{1'b0, 16'h2035, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h2035, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 16'hC000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hC000, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 16'h0000, 1'b0, 16'h4123, 1'b1, 1'b0, 1'b1, 16'hC000, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 16'h0000, 1'b0, 16'h2100, 1'b1, 1'b0, 1'b1, 16'h2100, 1'b1, 1'b0, 1'b0};
      for (int i = 6; i <= 10; i++)
         tbl[i] = '{1'b1, 16'h0000, 1'b0, 16'h4101, 1'b0, 1'b0, 1'b0, 16'h2100, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'h2035, 1'b0, 16'h4101, 1'b1, 1'b0, 1'b1, 16'h4101, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 16'h2035, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h4101, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 16'h2035, 1'b0, 16'hC101, 1'b1, 1'b0, 1'b1, 16'hC101, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 16'h2035, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h2035, 1'b1, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 16'hC000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hC000, 1'b1, 1'b1, 1'b0};
      tbl[16] = '{1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hC000, 1'b0, 1'b1, 1'b0};

      // Reset values, observed while reset is still asserted.
      rst_n           = 1'b0;
      pri_fifo_empty  = 1'b1;
      pri_fifo_data   = 16'h0;
      norm_fifo_empty = 1'b1;
      norm_fifo_data  = 16'h0;
      router_ready    = 1'b1;
      #12;
      chk("reset_flit_out",   flit_out,           16'h0);
      chk("reset_flit_valid", 16'(flit_valid),    16'h0);
      chk("reset_grant_pri",  16'(grant_pri),     16'h0);
      chk("reset_err_drop",   16'(err_drop),      16'h0);
      chk("reset_pri_rd",     16'(pri_fifo_rd),   16'h0);
      chk("reset_norm_rd",    16'(norm_fifo_rd),  16'h0);

      // Directed cycle table.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         pri_fifo_empty  = tbl[i].pe;
         pri_fifo_data   = tbl[i].pd;
         norm_fifo_empty = tbl[i].ne;
         norm_fifo_data  = tbl[i].nd;
         router_ready    = tbl[i].rdy;
         #2;
         chk($sformatf("v%0d_pri_rd", i),  16'(pri_fifo_rd),  16'(tbl[i].x_prd));
         chk($sformatf("v%0d_norm_rd", i), 16'(norm_fifo_rd), 16'(tbl[i].x_nrd));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_flit_out", i),   flit_out,         tbl[i].x_flit);
         chk($sformatf("v%0d_flit_valid", i), 16'(flit_valid),  16'(tbl[i].x_val));
         chk($sformatf("v%0d_grant_pri", i),  16'(grant_pri),   16'(tbl[i].x_gp));
         chk($sformatf("v%0d_err_drop", i),   16'(err_drop),    16'(tbl[i].x_err));
      end

      // Norm packet in flight when a pri packet arrives: no interleaving.
      do_reset();
      norm_q = '{16'h2201, 16'h4202, 16'hC203};
      step(1'b1);
      pri_q = '{16'h2035, 16'hC000};
      for (int c = 0; c < 40 && out_q.size() < 5; c++) step(1'b1);
      repeat (3) step(1'b1);
      exp_q = '{16'h2201, 16'h4202, 16'hC203, 16'h2035, 16'hC000};
      compare_out("atomic");
      chk("atomic_drops", 16'(drops), 16'd0);

      // Starvation: 4 pri packets, then norm, then pri resumes, under back-pressure.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         pri_q.push_back(16'h2040 + 16'(k));
         pri_q.push_back(16'hC040 + 16'(k));
      end
      norm_q = '{16'h2301, 16'hC302, 16'h2311, 16'hC312};
      for (int c = 0; c < 200 && out_q.size() < 16; c++) step((c % 3) != 2);
      repeat (4) step(1'b1);
      exp_q = '{16'h2040, 16'hC040, 16'h2041, 16'hC041, 16'h2042, 16'hC042,
                16'h2043, 16'hC043, 16'h2301, 16'hC302, 16'h2044, 16'hC044,
                16'h2045, 16'hC045, 16'h2311, 16'hC312};
      compare_out("starve");
      chk("starve_drops", 16'(drops), 16'd0);

      // Async reset mid-packet, then orphan flits dropped in IDLE.
      do_reset();
      pri_q = '{16'h2501, 16'h4502, 16'hC503};
      step(1'b1);
      chk("midpkt_grant_before", 16'(grant_pri), 16'h1);
      rst_n = 1'b0;
      #1;
      chk("areset_flit_out",   flit_out,          16'h0);
      chk("areset_flit_valid", 16'(flit_valid),   16'h0);
      chk("areset_grant_pri",  16'(grant_pri),    16'h0);
      chk("areset_pri_rd",     16'(pri_fifo_rd),  16'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pri_q.push_back(16'h2601);
      pri_q.push_back(16'hC601);
      out_q.delete();
      drops = 0;
      for (int c = 0; c < 40 && out_q.size() < 2; c++) step(1'b1);
      repeat (3) step(1'b1);
      exp_q = '{16'h2601, 16'hC601};
      compare_out("orphan");
      chk("orphan_drops", 16'(drops), 16'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
